// File: rtl/key_move_decoder.sv
// PS/2 W/A/S/D decoder: tracks make/break codes into a held-key vector and emits paced movement strobes.
// Define ARROW_KEYS_EN to map the extended arrow-key codes onto the same held bits.
module key_move_decoder #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       A_signal,
    output logic       D_signal,
    output logic       W_signal,
    output logic       S_signal,
    output logic [3:0] key_held
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       next_held;
    logic [CNT_W-1:0] count;
    logic             tick;

    // Masks are in key_held order {A,D,W,S}
    function automatic logic [3:0] letter_mask(input logic [7:0] code);
        case (code)
            8'h1C:   letter_mask = 4'b1000;
            8'h23:   letter_mask = 4'b0100;
            8'h1D:   letter_mask = 4'b0010;
            8'h1B:   letter_mask = 4'b0001;
            default: letter_mask = 4'b0000;
        endcase
    endfunction

`ifdef ARROW_KEYS_EN
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        case (code)
            8'h6B:   arrow_mask = 4'b1000;
            8'h74:   arrow_mask = 4'b0100;
            8'h75:   arrow_mask = 4'b0010;
            8'h72:   arrow_mask = 4'b0001;
            default: arrow_mask = 4'b0000;
        endcase
    endfunction
`endif

    assign tick = (count == CNT_MAX);

    always_comb begin
        next_state = state;
        next_held  = key_held;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == CODE_BREAK) begin
                        next_state = BRK;
                    end else if (rx_data == CODE_EXT) begin
                        next_state = EXT;
                    end else begin
                        next_held = key_held | letter_mask(rx_data);
                    end
                end
                BRK: begin
                    next_state = IDLE;
                    next_held  = key_held & ~letter_mask(rx_data);
                end
                EXT: begin
                    if (rx_data == CODE_BREAK) begin
                        next_state = EXT_BRK;
                    end else begin
                        next_state = IDLE;
`ifdef ARROW_KEYS_EN
                        next_held = key_held | arrow_mask(rx_data);
`endif
                    end
                end
                EXT_BRK: begin
                    next_state = IDLE;
`ifdef ARROW_KEYS_EN
                    next_held = key_held & ~arrow_mask(rx_data);
`endif
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Strobes sample the pre-update held vector, so a byte landing on a tick affects only the next tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            key_held <= 4'b0000;
            A_signal <= 1'b0;
            D_signal <= 1'b0;
            W_signal <= 1'b0;
            S_signal <= 1'b0;
        end else begin
            state    <= next_state;
            key_held <= next_held;
            count    <= tick ? '0 : count + 1'b1;
            A_signal <= tick & key_held[3] & ~key_held[2];
            D_signal <= tick & key_held[2] & ~key_held[3];
            W_signal <= tick & key_held[1] & ~key_held[0];
            S_signal <= tick & key_held[0] & ~key_held[1];
        end
    end

endmodule

// File: tb/tb_key_move_decoder.sv
// Scoreboard bench for key_move_decoder: a key-list reference model queues expected strobes and held vectors.
// Define ARROW_KEYS_EN for both RTL and bench to exercise the arrow-key table.
module tb_key_move_decoder;

    localparam int TICK_DIV = 4;
`ifdef ARROW_KEYS_EN
    localparam bit ARROW = 1'b1;
`else
    localparam bit ARROW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       A_signal, D_signal, W_signal, S_signal;
    logic [3:0] key_held;

    key_move_decoder #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .A_signal (A_signal),
        .D_signal (D_signal),
        .W_signal (W_signal),
        .S_signal (S_signal),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_idx;
        logic [3:0] vec;
    } strobe_t;

    strobe_t    strobe_q[$];
    logic [3:0] held_q[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_no = 0;
    bit         started = 1'b0;
    bit         running = 1'b1;

    // Reference model: key index 0=A, 1=D, 2=W, 3=S
    logic [7:0] letter_codes[4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
    logic [7:0] arrow_codes[4]  = '{8'h6B, 8'h74, 8'h75, 8'h72};
    bit         m_held[4];
    bit         m_break;
    bit         m_ext;
    int         m_phase;

    function automatic int find_key(input logic [7:0] b, input bit arrow);
        for (int i = 0; i < 4; i++) begin
            if (arrow ? (arrow_codes[i] == b) : (letter_codes[i] == b)) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] held_vec();
        return {m_held[0], m_held[1], m_held[2], m_held[3]};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (m_break) begin
            k = find_key(b, m_ext);
            if (k >= 0 && (!m_ext || ARROW)) m_held[k] = 1'b0;
            m_break = 1'b0;
            m_ext   = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) begin
                m_break = 1'b1;
            end else begin
                k = find_key(b, 1'b1);
                if (k >= 0 && ARROW) m_held[k] = 1'b1;
                m_ext = 1'b0;
            end
        end else if (b == 8'hF0) begin
            m_break = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            k = find_key(b, 1'b0);
            if (k >= 0) m_held[k] = 1'b1;
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
        strobe_t s;
        edge_no++;
        if (!r) begin
            for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
            m_break = 1'b0;
            m_ext   = 1'b0;
            m_phase = 0;
            strobe_q.delete();
        end else begin
            if (m_phase == TICK_DIV - 1) begin
                s.edge_idx = edge_no;
                s.vec = {m_held[0] && !m_held[1], m_held[1] && !m_held[0],
                         m_held[2] && !m_held[3], m_held[3] && !m_held[2]};
                if (s.vec != 4'b0000) strobe_q.push_back(s);
            end
            m_phase = (m_phase + 1) % TICK_DIV;
            if (v) model_byte(b);
        end
        held_q.push_back(held_vec());
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        model_edge(r, v, b);
        started = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b);
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compares every held vector, and pops a strobe entry whenever the DUT presents one
    always @(negedge clk) begin
        logic [3:0] strb;
        strobe_t    e;
        logic [3:0] h;
        if (started && running) begin
            strb = {A_signal, D_signal, W_signal, S_signal};
            if (held_q.size() == 0) begin
                checkOutput("held_queue_empty", 1, 0);
            end else begin
                h = held_q.pop_front();
                checkOutput("key_held", int'(key_held), int'(h));
            end
            if (strb != 4'b0000) begin
                if (strobe_q.size() == 0) begin
                    checkOutput("unexpected_strobe", int'(strb), 0);
                end else begin
                    e = strobe_q.pop_front();
                    checkOutput("strobe_edge", edge_no, e.edge_idx);
                    checkOutput("strobe_vec", int'(strb), int'(e.vec));
                end
            end else if (strobe_q.size() != 0 && strobe_q[0].edge_idx <= edge_no) begin
                e = strobe_q.pop_front();
                checkOutput("missing_strobe", 0, int'(e.vec));
            end
        end
    end

    initial begin
        logic [7:0] pool[11] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'hF0, 8'hE0,
                                 8'h6B, 8'h74, 8'h75, 8'h72, 8'h00};
        logic [7:0] b;

        do_reset();
        do_reset();

        // A make, then pulses every tick
        send(8'h1C);
        idle(10);
        send(8'hF0); send(8'h1C);
        idle(6);

        // A+D cancel, W alone fires
        send(8'h1C); send(8'h23);
        idle(8);
        send(8'h1D);
        idle(8);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23); send(8'hF0); send(8'h1D);
        idle(4);

        // Extended W make and break
        send(8'hE0); send(8'h75);
        idle(6);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(5);
        send(8'hE0); send(8'h1C);
        idle(5);

        // Reset mid-prefix: next byte is a make
        send(8'hF0);
        do_reset();
        send(8'h1B);
        idle(6);

        // Make landing on the tick cycle only affects the following tick
        do_reset();
        idle(3);
        send(8'h1D);
        idle(9);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else if ($urandom_range(0, 1) == 1) begin
                b = pool[$urandom_range(0, 10)];
                if (b == 8'h00) b = 8'($urandom);
                send(b);
            end else begin
                idle(1);
            end
        end
        idle(6);

        @(negedge clk);
        #1;
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
